// File: rtl/uart_pkg.sv
// uart_pkg: shared UART arbiter state encoding and frame timing defaults.
package uart_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_SPACE,
        ST_HOLD,
        ST_TAG
    } state_t;
    localparam int UART_DIV = 22;
    localparam int UART_FRAME_BITS = 10;
    // Two extra cycles for the transmitter's strobe sync, plus two of margin.
    localparam int FRAME_CYCLES_DEF = UART_DIV * UART_FRAME_BITS + 4;
    localparam logic [7:0] TAG_BASE_DEF = 8'hA0;
    function automatic logic [2:0] rr_next(logic [2:0] id, int n);
        return (int'(id) >= n - 1) ? 3'd0 : id + 3'd1;
    endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin pick of the first set request at or after ptr.
module rr_pick #(
    parameter int N = 3
) (
    input  logic [N-1:0] req,
    input  logic [2:0]   ptr,
    output logic [2:0]   idx,
    output logic         any
);
    // Walk offsets from farthest to nearest so the nearest hit overwrites.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int k = N - 1; k >= 0; k--)
            for (int i = 0; i < N; i++)
                if (req[i] && i == (int'(ptr) + k) % N) begin
                    idx = 3'(i);
                    any = 1'b1;
                end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-locked sharing of one UART byte transmitter.
// Define UART_TX_ARB_TAG_EN to prefix every packet with a TAG_BASE|grant_id byte.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ = 3,
`ifdef UART_TX_ARB_TAG_EN
    parameter logic [7:0] TAG_BASE = TAG_BASE_DEF,
`endif
    parameter int FRAME_CYCLES = FRAME_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*8-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   ack,
    output logic               tx_start,
    output logic [7:0]         tx_data,
    output logic               busy,
    output logic [2:0]         grant_id
);
    localparam int CW = $clog2(FRAME_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(FRAME_CYCLES - 1);

    state_t state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [2:0] ptr, ptr_nx, gid, gid_nx, pick;
    logic [7:0] data_q, data_nx, g_data;
    logic [N_REQ-1:0] gm;
    logic any, last_q, last_nx, boot, g_req, g_last;

    rr_pick #(.N(N_REQ)) u_pick (
        .req(req),
        .ptr(ptr),
        .idx(pick),
        .any(any)
    );

    assign gm = N_REQ'(1) << gid;
    assign g_req = |(req & gm);
    assign tx_data = data_nx;
    assign busy = state != ST_IDLE;
    assign grant_id = gid;

    always_comb begin
        g_data = '0;
        g_last = 1'b0;
        for (int i = 0; i < N_REQ; i++)
            if (gm[i]) begin
                g_data = req_data[8*i +: 8];
                g_last = req_last[i];
            end
    end

    // Reset leaves cnt at 0, so boot forces one full frame of quiet before the
    // first grant; a byte cut off by reset still finishes on the line.
    always_comb begin
        state_nx = state;
        cnt_nx = cnt;
        ptr_nx = ptr;
        gid_nx = gid;
        last_nx = last_q;
        data_nx = data_q;
        ack = '0;
        tx_start = 1'b0;
        case (state)
            ST_IDLE: begin
                if (boot) cnt_nx = CNT_LOAD;
                else if (cnt != '0) cnt_nx = cnt - CW'(1);
                else if (any) begin
                    gid_nx = pick;
`ifdef UART_TX_ARB_TAG_EN
                    state_nx = ST_TAG;
`else
                    state_nx = ST_ISSUE;
`endif
                end
            end
`ifdef UART_TX_ARB_TAG_EN
            ST_TAG: begin
                tx_start = 1'b1;
                data_nx = TAG_BASE | {5'd0, gid};
                cnt_nx = CNT_LOAD;
                last_nx = 1'b0;
                state_nx = ST_SPACE;
            end
`endif
            ST_ISSUE: begin
                tx_start = 1'b1;
                ack = gm;
                data_nx = g_data;
                cnt_nx = CNT_LOAD;
                last_nx = g_last;
                state_nx = ST_SPACE;
            end
            ST_SPACE: begin
                cnt_nx = cnt - CW'(1);
                if (cnt <= CW'(1)) begin
                    cnt_nx = '0;
                    ptr_nx = last_q ? rr_next(gid, N_REQ) : ptr;
                    state_nx = last_q ? ST_IDLE : ST_HOLD;
                end
            end
            ST_HOLD: begin
                ptr_nx = g_req ? ptr : rr_next(gid, N_REQ);
                state_nx = g_req ? ST_ISSUE : ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt <= '0;
            ptr <= '0;
            gid <= '0;
            last_q <= 1'b0;
            data_q <= '0;
            boot <= 1'b1;
        end else begin
            state <= state_nx;
            cnt <= cnt_nx;
            ptr <= ptr_nx;
            gid <= gid_nx;
            last_q <= last_nx;
            data_q <= data_nx;
            boot <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed table-driven bench for the shared UART transmitter arbiter.
// Build with UART_TX_ARB_TAG_EN defined to exercise the tag-byte variant.
module tb_uart_tx_arbiter;
    localparam int N = 3;
    localparam int F = 224;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [N-1:0] req = '0, req_last = '0, ack;
    logic [N*8-1:0] req_data = '0;
    logic tx_start, busy;
    logic [7:0] tx_data;
    logic [2:0] grant_id;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N_REQ(N), .FRAME_CYCLES(F)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .req_data(req_data),
        .req_last(req_last),
        .ack(ack),
        .tx_start(tx_start),
        .tx_data(tx_data),
        .busy(busy),
        .grant_id(grant_id)
    );

    typedef struct {int cyc; logic [7:0] data; logic [2:0] id; logic [N-1:0] ack;} ev_t;
    typedef struct {logic [7:0] data; logic [2:0] id; logic tag; int gap;} exp_t;

    ev_t log_q[$];
    exp_t vec[16];
    logic [8:0] mem[N][8];
    int wr[N], rd[N];
    int cyc_n = 0, tests = 0, fails = 0;
    logic busy_s;
    logic [N-1:0] ack_prev = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_ack"}, ack, 0);
        chk({name, "_tx_start"}, tx_start, 0);
        chk({name, "_tx_data"}, tx_data, 0);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_grant_id"}, grant_id, 0);
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req[i] = rd[i] < wr[i];
            req_last[i] = mem[i][rd[i] % 8][8];
            req_data[8*i +: 8] = mem[i][rd[i] % 8][7:0];
        end
    endtask

    task automatic push(input int i, input logic last, input logic [7:0] d);
        mem[i][wr[i]] = {last, d};
        wr[i]++;
    endtask

    // Log entries carry the posedge number at which the strobe is sampled.
    task automatic tick();
        logic [N-1:0] a;
        @(negedge clk);
        if (ack_prev != '0) chk("ack_width", ack, 0);
        ack_prev = ack;
        if (tx_start) log_q.push_back('{cyc_n + 1, tx_data, grant_id, ack});
        busy_s = busy;
        a = ack;
        @(posedge clk);
        #1;
        cyc_n++;
        for (int i = 0; i < N; i++) if (a[i]) rd[i]++;
        drive();
    endtask

    task automatic run_until(input int n, input int budget);
        int k = 0;
        while (log_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        if (log_q.size() < n) chk("timeout_tx_count", log_q.size(), n);
    endtask

    task automatic check_vecs(input int from, input int to);
        logic [N-1:0] ea;
        for (int i = from; i <= to; i++) begin
            ea = vec[i].tag ? '0 : N'(1) << vec[i].id;
            chk($sformatf("v%0d_data", i), log_q[i].data, vec[i].data);
            chk($sformatf("v%0d_grant", i), log_q[i].id, vec[i].id);
            chk($sformatf("v%0d_ack", i), log_q[i].ack, ea);
            if (vec[i].gap > 0)
                chk($sformatf("v%0d_gap", i), log_q[i].cyc - log_q[i-1].cyc, vec[i].gap);
        end
    endtask

    initial begin
        int t0, rel;
        for (int i = 0; i < N; i++) begin
            wr[i] = 0;
            rd[i] = 0;
            for (int j = 0; j < 8; j++) mem[i][j] = '0;
        end
`ifdef UART_TX_ARB_TAG_EN
        vec[0] = '{8'hA1, 3'd1, 1'b1, 0};
        vec[1] = '{8'h7E, 3'd1, 1'b0, F + 1};
`else
        vec[0]  = '{8'h55, 3'd0, 1'b0, 0};
        vec[1]  = '{8'h11, 3'd1, 1'b0, 0};
        vec[2]  = '{8'h22, 3'd1, 1'b0, F + 1};
        vec[3]  = '{8'h33, 3'd1, 1'b0, F + 1};
        vec[4]  = '{8'hAA, 3'd0, 1'b0, F + 1};
        vec[5]  = '{8'hB1, 3'd2, 1'b0, 0};
        vec[6]  = '{8'hA0, 3'd0, 1'b0, F + 2};
        vec[7]  = '{8'hC1, 3'd2, 1'b0, 0};
        vec[8]  = '{8'hC2, 3'd2, 1'b0, 0};
        vec[9]  = '{8'h01, 3'd0, 1'b0, 0};
        vec[10] = '{8'h11, 3'd1, 1'b0, F + 1};
        vec[11] = '{8'h21, 3'd2, 1'b0, F + 1};
        vec[12] = '{8'h02, 3'd0, 1'b0, F + 1};
        vec[13] = '{8'h12, 3'd1, 1'b0, F + 1};
        vec[14] = '{8'h22, 3'd2, 1'b0, F + 1};
`endif
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;
        repeat (F + 10) tick();

`ifdef UART_TX_ARB_TAG_EN
        push(1, 1'b1, 8'h7E);
        drive();
        t0 = cyc_n;
        run_until(2, 4 * F);
        chk("tag_latency", log_q[0].cyc - t0, 2);
        chk("data_latency", log_q[1].cyc - t0, 2 + F + 1);
        check_vecs(0, 1);
        repeat (F + 10) tick();
        chk("extra_tx", log_q.size(), 2);
`else
        push(0, 1'b1, 8'h55);
        drive();
        t0 = cyc_n;
        run_until(1, 20);
        chk("t1_latency", log_q[0].cyc - t0, 2);
        check_vecs(0, 0);
        while (cyc_n < t0 + F + 1) tick();
        chk("t1_busy_in_space", busy_s, 1);
        tick();
        tick();
        chk("t1_busy_idle", busy_s, 0);
        repeat (10) tick();
        chk("t1_single_tx", log_q.size(), 1);

        push(1, 1'b0, 8'h11);
        push(1, 1'b0, 8'h22);
        push(1, 1'b1, 8'h33);
        push(0, 1'b1, 8'hAA);
        drive();
        run_until(5, 6 * F);
        check_vecs(1, 4);

        push(2, 1'b0, 8'hB1);
        push(2, 1'b0, 8'hB2);
        push(0, 1'b1, 8'hA0);
        drive();
        run_until(6, 3 * F);
        repeat (50) tick();
        wr[2] = rd[2];
        drive();
        run_until(7, 3 * F);
        check_vecs(5, 6);

        push(2, 1'b0, 8'hC1);
        push(2, 1'b1, 8'hC2);
        drive();
        run_until(8, 3 * F);
        repeat (123) tick();
        rst_n = 1'b0;
        #1;
        chk_zero("abort");
        repeat (3) tick();
        rst_n = 1'b1;
        rel = cyc_n;
        run_until(9, 3 * F);
        tests++;
        if (log_q[8].cyc - rel < F || log_q[8].cyc - rel > F + 2) begin
            fails++;
            $display("FAIL post_reset_gap: got %0d, expected %0d..%0d", log_q[8].cyc - rel, F, F + 2);
        end
        check_vecs(7, 8);

        push(0, 1'b1, 8'h01);
        push(0, 1'b1, 8'h02);
        push(1, 1'b1, 8'h11);
        push(1, 1'b1, 8'h12);
        push(2, 1'b1, 8'h21);
        push(2, 1'b1, 8'h22);
        drive();
        run_until(15, 8 * F);
        check_vecs(9, 14);
        repeat (F + 10) tick();
        chk("extra_tx", log_q.size(), 15);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART byte transmitter (8N1, fixed divider) between N byte-stream requesters, such as the camera pixel streamer, the command echo and the status reporter.
- Performs round-robin arbitration with packet lock: a granted requester keeps the transmitter until its byte flagged last has been sent.
- Drives the transmitter's one-cycle data-ready strobe and data byte.
- The transmitter has no busy output, so this block enforces the frame spacing with its own counter.

Parameters:
- N_REQ, 3, number of requesters (2..8).
- FRAME_CYCLES, 224, clk cycles from one tx_start pulse to the earliest next tx_start. Must cover the transmitter's full start+8 data+stop frame (≥222 at the current divider).
- TAG_BASE, 8'hA0, upper bits of the tag byte (optional feature only).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  N_REQ  per-requester byte-valid, level; held until ack.
- req_data  in  N_REQ*8  packed bytes; requester i uses bits [8i+7:8i].
- req_last  in  N_REQ  marks the presented byte as the final byte of the packet.
- ack  out  N_REQ  one-cycle pulse: byte of requester i consumed this cycle.
- tx_start  out  1  one-cycle strobe to the transmitter's data-ready input.
- tx_data  out  8  byte to the transmitter, valid in the tx_start cycle and held afterwards.
- busy  out  1  high while any packet is locked or a frame is in flight.
- grant_id  out  3  index of the current/last granted requester.

Behaviour:
- Reset (async, rst_n=0), all outputs low:
  - ack=0, tx_start=0, tx_data=0, busy=0, grant_id=0.
  - Round-robin pointer=0, frame counter=0, FSM=IDLE.
  - Asserting rst_n mid-frame aborts sequencing immediately. A byte already handed to the transmitter still completes on the line; after release, the first tx_start is not issued before FRAME_CYCLES from reset release.
- FSM states: IDLE, ISSUE, SPACE, HOLD.
- IDLE:
  - If any req is high, select the first requester at or after the pointer (cyclic) and latch grant_id.
  - Next state is ISSUE.
  - Same-cycle multiple requests are resolved by the pointer only.
- ISSUE (1 cycle):
  - tx_start=1, tx_data=req_data[grant], ack[grant]=1 in the same cycle.
  - Load the frame counter with FRAME_CYCLES-1.
  - Latch the last flag. Next state is SPACE.
- SPACE:
  - Counter decrements each cycle. When it reaches 0:
    - If the latched last flag is set: pointer=(grant_id+1) mod N_REQ, go to IDLE.
    - Otherwise go to HOLD.
- HOLD (packet locked):
  - Granted req high -> ISSUE.
  - Granted req low -> packet abandoned: release lock, advance pointer as on last, go to IDLE.
  - Other requesters are ignored while locked.
- Latency:
  - Request in IDLE to tx_start: 2 cycles.
  - Back-to-back bytes are exactly FRAME_CYCLES+1 apart (the extra cycle is HOLD), or FRAME_CYCLES+1 between packets (the extra cycle is IDLE).
- busy: high in ISSUE, SPACE and HOLD; low in IDLE.
- tx_start never pulses while the counter is nonzero; this is an invariant.
- A req change during SPACE has no effect until HOLD/IDLE samples it.
- grant_id is zero-extended for N_REQ<8.

Optional Feature:
- Macro: UART_TX_ARB_TAG_EN.
- Defined:
  - Each packet is preceded by one tag byte, TAG_BASE | grant_id. It is sent from a TAG state inserted between IDLE and ISSUE, with the same tx_start strobe and SPACE spacing.
  - No ack is given for the tag byte.
  - First data byte latency becomes 2+FRAME_CYCLES+1 cycles.
- Undefined: no TAG state; raw bytes only.

Decomposition:
- Shared package (uart_pkg): FSM state encoding, the default FRAME_CYCLES value tied to the UART divider, and the TAG_BASE default.
- One sub-module, rr_pick: combinational round-robin first-one-from-pointer over N_REQ. It is reused later for RX command dispatch.
- Frame counter and FSM stay in the top.

Test Plan:
1. Single byte: req[0]=1, data 8'h55, last=1 at t0 -> tx_start and ack[0] at t0+2, tx_data=8'h55; busy low at t0+2+FRAME_CYCLES+1; no second tx_start.
2. Packet lock: req[1] sends 3 bytes (11,22,33; last on 33) while req[0] is held high -> tx_start strobes 225 cycles apart all carry requester 1 bytes; requester 0 byte follows only after 33.
3. Fairness: all three req high continuously, single-byte packets -> grant sequence 0,1,2,0,1,2; each ack one cycle wide.
4. Abandon: req[2] sends non-last byte, then drops req during SPACE -> no further tx_start for 2; pointer advances; pending req[0] granted next.
5. Reset mid-SPACE: assert rst_n=0 for 3 cycles at counter=100 -> all outputs 0 asynchronously; after release, the next tx_start comes no sooner than FRAME_CYCLES cycles later.
6. With UART_TX_ARB_TAG_EN: req[1] single byte 8'h7E -> tx_data 8'hA1 (no ack), then 8'h7E with ack[1] FRAME_CYCLES+1 cycles later.
